// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and default datapath width for the alu block.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam int ALU_WIDTH = 4;

endpackage

// File: rtl/alu_full_adder.sv
// full_adder: 1-bit full adder, one link of the alu ripple-carry chain.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/alu.sv
// alu: registered WIDTH-bit add/sub/and/or unit with carry/borrow flag.
//   clk, reset     : clock, synchronous active-high reset
//   a, b           : unsigned operands
//   alu_select     : opcode (ADD/SUB/AND/OR, see alu_pkg)
//   alu_output     : registered result, valid one edge after inputs
//   alu_carry_out  : registered carry (ADD) / borrow (SUB), 0 for logic ops
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_select,
  output logic [WIDTH-1:0] alu_output,
  output logic             alu_carry_out
);

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_flag;

  logic [WIDTH-1:0] r_out;
  logic             r_carry;

  // SUB reuses the adder as a + ~b + 1: invert B and inject the +1 as cin0.
  assign w_sub   = (alu_select == ALU_SUB);
  assign w_b_eff = b ^ {WIDTH{w_sub}};
  assign w_c[0]  = w_sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (w_b_eff[i]),
      .cin  (w_c[i]),
      .sum  (w_sum[i]),
      .cout (w_c[i+1])
    );
  end

  always_comb begin
    w_res  = '0;
    w_flag = 1'b0;
    case (alu_select)
      ALU_ADD: begin
        w_res  = w_sum;
        w_flag = w_c[WIDTH];
      end
      ALU_SUB: begin
        // Two's-complement carry-out is 1 when no borrow, so invert it.
        w_res  = w_sum;
        w_flag = ~w_c[WIDTH];
      end
      ALU_AND: w_res = a & b;
      ALU_OR:  w_res = a | b;
      default: begin
        w_res  = '0;
        w_flag = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_out   <= w_res;
      r_carry <= w_flag;
    end
  end

  assign alu_output    = r_out;
  assign alu_carry_out = r_carry;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic       clk;
  logic       reset;
  logic [3:0] a, b;
  logic [1:0] sel;
  logic [3:0] out4;
  logic       c4;
  logic [7:0] a8, b8;
  logic [1:0] sel8;
  logic [7:0] out8;
  logic       c8;

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alu_select(sel),
    .alu_output(out4), .alu_carry_out(c4)
  );

  alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .alu_select(sel8),
    .alu_output(out8), .alu_carry_out(c8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] eo;
    logic       ec;
  } vec_t;

  vec_t tbl[8];

  // Reference: plain integer arithmetic on the opcode meaning.
  function automatic logic [4:0] model(input int av, input int bv, input int op);
    int r;
    int o;
    int f;
    case (op)
      0: begin r = av + bv; o = r % 16; f = (r > 15) ? 1 : 0; end
      1: begin o = (av - bv + 16) % 16; f = (av < bv) ? 1 : 0; end
      2: begin o = av & bv; f = 0; end
      default: begin o = av | bv; f = 0; end
    endcase
    return {1'(f), 4'(o)};
  endfunction

  task automatic chk(input string name, input logic [3:0] go, input logic gc,
                     input logic [3:0] eo, input logic ec);
    checks++;
    if (go !== eo || gc !== ec) begin
      errors++;
      $display("FAIL %s: got out=%h carry=%b, expected out=%h carry=%b", name, go, gc, eo, ec);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] e;
    logic [4:0] prev;
    logic [3:0] ra, rb;
    logic [1:0] rs;
    logic       rr;

    tbl[0] = '{4'hF, 4'hF, 2'd0, 4'hE, 1'b1};
    tbl[1] = '{4'h3, 4'h4, 2'd0, 4'h7, 1'b0};
    tbl[2] = '{4'h1, 4'hE, 2'd1, 4'h3, 1'b1};
    tbl[3] = '{4'h0, 4'h0, 2'd1, 4'h0, 1'b0};
    tbl[4] = '{4'hE, 4'h1, 2'd1, 4'hD, 1'b0};
    tbl[5] = '{4'h1, 4'hE, 2'd2, 4'h0, 1'b0};
    tbl[6] = '{4'hF, 4'hF, 2'd2, 4'hF, 1'b0};
    tbl[7] = '{4'hE, 4'h1, 2'd3, 4'hF, 1'b0};

    a8 = 8'h00; b8 = 8'h00; sel8 = 2'd0;

    // Reset held with live operands: outputs stay cleared.
    reset = 1'b1; a = 4'hF; b = 4'hF; sel = 2'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", out4, c4, 4'h0, 1'b0);
    end
    reset = 1'b0;
    tick();
    chk("reset_release", out4, c4, 4'hE, 1'b1);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      a = tbl[i].a; b = tbl[i].b; sel = tbl[i].sel;
      tick();
      chk($sformatf("table_%0d", i), out4, c4, tbl[i].eo, tbl[i].ec);
    end

    // Pipeline: new inputs every cycle; output must hold the previous
    // result until the edge, then show the new one.
    prev = {1'b0, 4'hF};  // last table entry: OR E|1 = F, carry 0
    for (int i = 0; i < 16; i++) begin
      a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); sel = 2'(i % 4);
      #2;
      chk("pipe_hold", out4, c4, prev[3:0], prev[4]);
      e = model(int'(a), int'(b), int'(sel));
      tick();
      chk("pipe_next", out4, c4, e[3:0], e[4]);
      prev = e;
    end

    // Mid-stream reset clears at that edge, next edge resumes normally.
    a = 4'hF; b = 4'hF; sel = 2'd0; reset = 1'b1;
    tick();
    chk("mid_reset", out4, c4, 4'h0, 1'b0);
    reset = 1'b0; a = 4'h2; b = 4'h9; sel = 2'd1;
    tick();
    chk("post_reset", out4, c4, 4'h9, 1'b1);

    // Exhaustive sweep against the model.
    for (int op = 0; op < 4; op++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          a = 4'(x); b = 4'(y); sel = 2'(op);
          e = model(x, y, op);
          tick();
          chk($sformatf("exh_op%0d_%h_%h", op, x, y), out4, c4, e[3:0], e[4]);
        end
      end
    end

    // Randomised stream with occasional reset.
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(15)); rb = 4'($urandom_range(15));
      rs = 2'($urandom_range(3));  rr = ($urandom_range(15) == 0);
      a = ra; b = rb; sel = rs; reset = rr;
      e = rr ? 5'd0 : model(int'(ra), int'(rb), int'(rs));
      tick();
      chk("random", out4, c4, e[3:0], e[4]);
    end
    reset = 1'b0;

    // WIDTH=8 spot check: FF + 01 wraps to 00 with carry.
    a8 = 8'hFF; b8 = 8'h01; sel8 = 2'd0;
    tick();
    checks++;
    if (out8 !== 8'h00 || c8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_add: got out=%h carry=%b, expected out=00 carry=1", out8, c8);
    end
    a8 = 8'h10; b8 = 8'h20; sel8 = 2'd1;
    tick();
    checks++;
    if (out8 !== 8'hF0 || c8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_sub: got out=%h carry=%b, expected out=f0 carry=1", out8, c8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
